// File: rtl/btb_if.sv
// Fetch / resolve port bundle for the branch target buffer.
//   master : drives fetch_pc, the update port and flush_all; observes the
//            prediction and the performance counters
//   slave  : the predictor itself
// Signals:
//   fetch_pc          PC being fetched this cycle
//   predicted_taken   lookup hit with a taken-leaning counter
//   predicted_target  stored target on a taken prediction, else fetch_pc+4
//   update_en         execute stage resolved a jump/branch
//   update_pc         PC of the resolved instruction
//   update_target     resolved target address
//   update_taken      resolved direction (1 = taken)
//   mispredict        execute redirected the PC this cycle
//   flush_all         invalidate every entry at the next edge
//   lookup_count      saturating count of update_en cycles
//   mispred_count     saturating count of update_en & mispredict cycles
interface btb_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      fetch_pc;
    logic             predicted_taken;
    logic [31:0]      predicted_target;
    logic             update_en;
    logic [31:0]      update_pc;
    logic [31:0]      update_target;
    logic             update_taken;
    logic             mispredict;
    logic             flush_all;
    logic [CNT_W-1:0] lookup_count;
    logic [CNT_W-1:0] mispred_count;

    modport master (
        output fetch_pc, update_en, update_pc, update_target, update_taken,
               mispredict, flush_all,
        input  predicted_taken, predicted_target, lookup_count, mispred_count
    );

    modport slave (
        input  fetch_pc, update_en, update_pc, update_target, update_taken,
               mispredict, flush_all,
        output predicted_taken, predicted_target, lookup_count, mispred_count
    );
endinterface

// File: rtl/btb_predictor.sv
// Fetch-stage branch target buffer with 2-bit saturating direction counters.
// Direct-mapped: index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous reset, active low
//   bus    btb_if slave: fetch lookup, resolve/update port, flush, perf counters
// Lookup is purely combinational on the registered table, so an update to
// the same index in the same cycle is only visible from the next cycle on.
module btb_predictor #(
    parameter int ENTRIES = 8,
    parameter int IDX_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic  clk,
    input  logic  rst_n,
    btb_if.slave  bus
);

    localparam int TAG_W = 32 - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         cnt_q    [ENTRIES];
    logic [1:0]         cnt_d    [ENTRIES];
    logic [CNT_W-1:0]   lookup_q, lookup_d;
    logic [CNT_W-1:0]   mispred_q, mispred_d;

    logic [IDX_W-1:0]   f_idx, u_idx;
    logic [TAG_W-1:0]   f_tag, u_tag;
    logic               f_hit, u_hit, f_taken;

    // PC bits [1:0] never take part in index or tag.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bus.fetch_pc[1:0], bus.update_pc[1:0]};

    // ---------------- lookup ----------------
    assign f_idx   = bus.fetch_pc[IDX_W+1:2];
    assign f_tag   = bus.fetch_pc[31:IDX_W+2];
    assign f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign f_taken = f_hit && cnt_q[f_idx][1];

    assign bus.predicted_taken  = f_taken;
    assign bus.predicted_target = f_taken ? target_q[f_idx] : bus.fetch_pc + 32'd4;
    assign bus.lookup_count     = lookup_q;
    assign bus.mispred_count    = mispred_q;

    // ---------------- update ----------------
    assign u_idx = bus.update_pc[IDX_W+1:2];
    assign u_tag = bus.update_pc[31:IDX_W+2];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;

        // Flush wins over a same-cycle update; cnt/target are left as-is.
        if (bus.flush_all) begin
            valid_d = '0;
        end else if (bus.update_en) begin
            if (u_hit) begin
                if (bus.update_taken) begin
                    cnt_d[u_idx]    = (cnt_q[u_idx] == 2'b11) ? 2'b11 : cnt_q[u_idx] + 2'd1;
                    target_d[u_idx] = bus.update_target;
                end else begin
                    cnt_d[u_idx]    = (cnt_q[u_idx] == 2'b00) ? 2'b00 : cnt_q[u_idx] - 2'd1;
                end
            end else if (bus.update_taken) begin
                // Allocate (or evict an alias) in weakly-taken state.
                valid_d[u_idx]  = 1'b1;
                tag_d[u_idx]    = u_tag;
                target_d[u_idx] = bus.update_target;
                cnt_d[u_idx]    = 2'b10;
            end
        end
    end

    // Perf counters ignore flush and saturate at all-ones.
    always_comb begin
        lookup_d  = lookup_q;
        mispred_d = mispred_q;
        if (bus.update_en) begin
            if (lookup_q != CNT_MAX) begin
                lookup_d = lookup_q + CNT_ONE;
            end
            if (bus.mispredict && (mispred_q != CNT_MAX)) begin
                mispred_d = mispred_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= '0;
            lookup_q  <= '0;
            mispred_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= 2'b01;
            end
        end else begin
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            target_q  <= target_d;
            cnt_q     <= cnt_d;
            lookup_q  <= lookup_d;
            mispred_q <= mispred_d;
        end
    end

endmodule
